muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised, iterative multiply/divide unit with architectural HI/LO registers, serving the EX stage of the pipeline CPU. It executes MIPS32 DIV/DIVU/MULT/MULTU/MUL plus the accumulate ops MADD/MADDU/MSUB/MSUBU over WIDTH cycles using one shared shift-add/subtract datapath. It handles MFHI/MFLO/MTHI/MTLO in a single cycle, signals stalls to the pipeline hazard unit, and supports flush (kill) of an in-flight operation.

## Interface
- WIDTH, 32: operand, HI and LO width; must be ≥ 4.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Md_valid  in  1  Md_op is a real instruction this cycle. The pipeline holds it high, with Md_op and operands stable, while Md_stall is high.
- Md_op  in  4  op code: 0000 NOP, 0001 DIV, 0010 DIVU, 0011 MFHI, 0100 MFLO, 0101 MTHI, 0110 MTLO, 0111 MUL, 1000 MULT, 1001 MULTU, 1010 MADD, 1011 MADDU, 1100 MSUB, 1101 MSUBU; 1110/1111 are treated as NOP.
- Md_kill  in  1  flush; aborts any in-flight op.
- Rs_in  in  WIDTH  first operand (dividend / multiplicand / MTxx source).
- Rt_in  in  WIDTH  second operand (divisor / multiplier).
- Res_out  out  WIDTH  result for MFHI, MFLO and MUL.
- Md_stall  out  1  hold the pipeline (combinational).
- Div_zero  out  1  the divide completing this cycle had a zero divisor.

## Operation
- State is IDLE / BUSY / DONE, with an iteration counter of clog2(WIDTH) bits.
- **IDLE**
  - Md_valid with an arithmetic op (DIV..MSUBU excluding MFxx/MTxx) starts an operation.
  - It captures |Rs|, |Rt| (absolute values for signed ops, raw for unsigned), the result-sign flags, the op, and a HI/LO snapshot (for MADD/MSUB).
  - It loads counter = WIDTH-1 and moves to BUSY.
- **BUSY**
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring shift-subtract step per cycle.
  - At counter = 0 the unit applies the sign fix, writes the results and moves to DONE.
- **DONE**: lasts one cycle, then returns to IDLE unconditionally.
- **Result rules**
  - MULT/MULTU: {HI,LO} = full 2·WIDTH product.
  - MUL: HI/LO are unchanged; the low WIDTH bits of the signed product go to Res_out in DONE.
  - MADD(U)/MSUB(U): {HI,LO} = snapshot ± product, modulo 2^(2·WIDTH).
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIV of MIN by -1: LO = MIN, HI = 0.
  - Divide by zero: LO = all ones and HI = Rs_in (raw). Div_zero is high in DONE. The latency is the same as a normal divide.
- **Single-cycle ops** (only in IDLE or DONE)
  - MTHI/MTLO write HI/LO at the edge.
  - MFHI/MFLO drive Res_out = HI/LO combinationally and never stall.
- **Res_out**
  - MFHI selects HI and MFLO selects LO.
  - In DONE with op MUL it carries the MUL result.
  - Otherwise it is 0.
- **Md_kill**
  - At any edge it forces IDLE, cancels the pending HI/LO write, and leaves HI/LO unchanged.
  - Md_kill has priority over a start in the same cycle.
- **Reset**
  - State is IDLE and HI = LO = 0.
  - Md_stall = 0, Div_zero = 0.
  - Res_out = 0 unless Md_valid with MFHI/MFLO.
  - Reset mid-BUSY discards the operation.

## Timing
- Md_stall = Md_valid & (arith op) & (state ≠ DONE).
- Issue cycle is T. BUSY runs T+1..T+WIDTH and DONE is T+WIDTH+1.
  - Md_stall is high for WIDTH+1 cycles and low in DONE, where the held instruction retires.
  - HI/LO are visible from the DONE cycle onward.
- In DONE a held arithmetic op must not restart. A new arithmetic op is accepted only from IDLE, so back-to-back arithmetic ops have one unstalled cycle between starts.
- MFHI/MFLO in the cycle right after DONE see the new values (no bypass needed).
- Md_kill while Md_valid stays high with the same op: no restart in that cycle. The pipeline deasserts Md_valid on flush.

## Structure
- muldiv_pkg holds:
  - the op-code localparams (MD_DIV … MD_MSUBU);
  - the state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - helper functions is_arith / is_signed / is_div.
- Sub-module muldiv_seq_core is the WIDTH-parametrised iterative datapath: shift registers, adder/subtractor and counter, with start/mode in and done/hi/lo out.
- The top level keeps the FSM, HI/LO, sign handling, accumulate and output muxing.

## Test plan
All scenarios use WIDTH = 32.
1. MULT Rs=0xFFFFFFFE, Rt=3 → Md_stall high for exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
3. DIVU 5/0 → HI=5, LO=0xFFFFFFFF, Div_zero high only in the DONE cycle.
4. MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Then MSUB 1×1 → HI=0, LO=0xFFFFFFFF.
5. MTLO 0x1234, MULTU started, Md_kill at BUSY cycle 10 → Md_stall drops and MFLO returns 0x1234.
6. Rst_n low mid-DIV → immediately IDLE, HI=LO=0, Md_stall=0. A subsequent MUL 6×7 gives Res_out=42 in DONE with HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and op-class helpers shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_DIV   = 4'd1;
  localparam logic [3:0] MD_DIVU  = 4'd2;
  localparam logic [3:0] MD_MFHI  = 4'd3;
  localparam logic [3:0] MD_MFLO  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MUL   = 4'd7;
  localparam logic [3:0] MD_MULT  = 4'd8;
  localparam logic [3:0] MD_MULTU = 4'd9;
  localparam logic [3:0] MD_MADD  = 4'd10;
  localparam logic [3:0] MD_MADDU = 4'd11;
  localparam logic [3:0] MD_MSUB  = 4'd12;
  localparam logic [3:0] MD_MSUBU = 4'd13;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  function automatic logic is_arith(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU || (op >= MD_MUL && op <= MD_MSUBU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return op == MD_DIV || op == MD_MUL || op == MD_MULT || op == MD_MADD || op == MD_MSUB;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_seq_core.sv
// muldiv_seq_core: WIDTH-step unsigned shift-add multiplier / restoring divider (start,div,a,b in; done,hi,lo out)
module muldiv_seq_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic             busy, div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m, r_hi, r_lo;
  logic [WIDTH:0]   x, s, t;
  logic             take;

  // hi/lo are the register values after this cycle's step; the top samples them when done is high
  always_comb begin
    x    = div_q ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
    s    = x + (div_q ? ~{1'b0, m} : {1'b0, m}) + {{WIDTH{1'b0}}, div_q};
    take = div_q ? ~s[WIDTH] : r_lo[0];
    t    = take ? s : x;
    hi   = div_q ? t[WIDTH-1:0] : t[WIDTH:1];
    lo   = div_q ? {r_lo[WIDTH-2:0], take} : {t[0], r_lo[WIDTH-1:1]};
  end

  assign done = busy && cnt == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      m     <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (kill) begin
      busy <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= div;
      cnt   <= CW'(WIDTH - 1);
      m     <= b;
      r_hi  <= '0;
      r_lo  <= a;
    end else if (busy) begin
      r_hi <= hi;
      r_lo <= lo;
      cnt  <= cnt - 1'b1;
      busy <= cnt != '0;
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: MIPS multiply/divide unit with HI/LO (md_valid,md_op,md_kill,rs_in,rt_in in; res_out,md_stall,div_zero out)
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_valid,
  input  logic [3:0]       md_op,
  input  logic             md_kill,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  output logic [WIDTH-1:0] res_out,
  output logic             md_stall,
  output logic             div_zero
);
  state_t               state;
  logic [WIDTH-1:0]     hi, lo, rs_q, mul_res, abs_a, abs_b, core_hi, core_lo, q, r;
  logic [3:0]           op_q;
  logic [2*WIDTH-1:0]   acc, sp, fin;
  logic                 start, sa, sb, neg_a, neg_b, rz, core_done;

  assign start = md_valid && is_arith(md_op) && state == ST_IDLE && !md_kill;
  assign sa    = is_signed(md_op) && rs_in[WIDTH-1];
  assign sb    = is_signed(md_op) && rt_in[WIDTH-1];
  assign abs_a = sa ? -rs_in : rs_in;
  assign abs_b = sb ? -rt_in : rt_in;

  muldiv_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .kill  (md_kill),
    .div   (is_div(md_op)),
    .a     (abs_a),
    .b     (abs_b),
    .done  (core_done),
    .hi    (core_hi),
    .lo    (core_lo)
  );

  // remainder takes the dividend's sign; a zero divisor returns LO=all ones, HI=raw dividend
  always_comb begin
    sp  = (neg_a ^ neg_b) ? -{core_hi, core_lo} : {core_hi, core_lo};
    q   = (neg_a ^ neg_b) ? -core_lo : core_lo;
    r   = neg_a ? -core_hi : core_hi;
    fin = is_div(op_q) ? (rz ? {rs_q, {WIDTH{1'b1}}} : {r, q}) :
          (op_q == MD_MADD || op_q == MD_MADDU) ? acc + sp :
          (op_q == MD_MSUB || op_q == MD_MSUBU) ? acc - sp : sp;
  end

  assign md_stall = md_valid && is_arith(md_op) && state != ST_DONE;
  assign res_out  = (md_valid && md_op == MD_MFHI) ? hi :
                    (md_valid && md_op == MD_MFLO) ? lo :
                    (state == ST_DONE && op_q == MD_MUL) ? mul_res : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      rs_q     <= '0;
      mul_res  <= '0;
      op_q     <= MD_NOP;
      acc      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      rz       <= 1'b0;
      div_zero <= 1'b0;
    end else if (md_kill) begin
      state    <= ST_IDLE;
      div_zero <= 1'b0;
    end else if (state == ST_BUSY) begin
      if (core_done) begin
        state    <= ST_DONE;
        div_zero <= is_div(op_q) && rz;
        if (op_q == MD_MUL) mul_res <= sp[WIDTH-1:0];
        else {hi, lo} <= fin;
      end
    end else begin
      div_zero <= 1'b0;
      state    <= start ? ST_BUSY : ST_IDLE;
      if (start) begin
        op_q  <= md_op;
        rs_q  <= rs_in;
        rz    <= rt_in == '0;
        neg_a <= sa;
        neg_b <= sb;
        acc   <= {hi, lo};
      end else if (md_valid && md_op == MD_MTHI) begin
        hi <= rs_in;
      end else if (md_valid && md_op == MD_MTLO) begin
        lo <= rs_in;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus kill/reset/back-to-back sequences for muldiv_seq
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b1, md_valid = 1'b0, md_kill = 1'b0;
  logic [3:0]  md_op = MD_NOP;
  logic [31:0] rs_in = '0, rt_in = '0, res_out;
  logic        md_stall, div_zero;
  int          checks = 0, failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pre_hi, pre_lo, rs, rt, hi, lo, res;
    logic        dz;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_valid (md_valid),
    .md_op    (md_op),
    .md_kill  (md_kill),
    .rs_in    (rs_in),
    .rt_in    (rt_in),
    .res_out  (res_out),
    .md_stall (md_stall),
    .div_zero (div_zero)
  );

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] ph, pl, a, b, h, l, res, input logic dz);
    vec_t v;
    v.op = op; v.pre_hi = ph; v.pre_lo = pl; v.rs = a; v.rt = b;
    v.hi = h; v.lo = l; v.res = res; v.dz = dz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    md_valid = 1'b1; md_op = op; rs_in = v;
    @(negedge clk);
    md_valid = 1'b0; md_op = MD_NOP;
  endtask

  task automatic rd(input string nm, input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    md_valid = 1'b1; md_op = MD_MFHI; #1;
    chk({nm, ".hi"}, res_out, h);
    md_op = MD_MFLO; #1;
    chk({nm, ".lo"}, res_out, l);
    chk({nm, ".mf_stall"}, 32'(md_stall), 32'd0);
    md_valid = 1'b0; md_op = MD_NOP;
  endtask

  task automatic run(input vec_t v, input bit pre, input string nm);
    int n;
    bit dz_early;
    if (pre) begin
      mt(MD_MTHI, v.pre_hi);
      mt(MD_MTLO, v.pre_lo);
    end
    @(negedge clk);
    md_valid = 1'b1; md_op = v.op; rs_in = v.rs; rt_in = v.rt; #1;
    n = 0; dz_early = 1'b0;
    while (md_stall && n < 100) begin
      dz_early = dz_early | div_zero;
      @(negedge clk); #1;
      n++;
    end
    chk({nm, ".stall_cycles"}, 32'(n), 32'd33);
    chk({nm, ".dz_done"}, 32'(div_zero), 32'(v.dz));
    chk({nm, ".dz_early"}, 32'(dz_early), 32'd0);
    chk({nm, ".res_done"}, res_out, v.res);
    @(negedge clk);
    md_valid = 1'b0; md_op = MD_NOP; #1;
    chk({nm, ".dz_after"}, 32'(div_zero), 32'd0);
    rd(nm, v.hi, v.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = mk(MD_MULT,  0, 0, 32'hFFFFFFFE, 3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
    vecs[1]  = mk(MD_DIV,   0, 0, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    vecs[2]  = mk(MD_DIV,   0, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0);
    vecs[3]  = mk(MD_DIVU,  0, 0, 5, 0, 5, 32'hFFFFFFFF, 0, 1);
    vecs[4]  = mk(MD_MADDU, 0, 32'hFFFFFFFF, 1, 1, 1, 0, 0, 0);
    vecs[5]  = mk(MD_MSUB,  1, 0, 1, 1, 0, 32'hFFFFFFFF, 0, 0);
    vecs[6]  = mk(MD_MULTU, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0);
    vecs[7]  = mk(MD_DIVU,  0, 0, 100, 7, 2, 14, 0, 0);
    vecs[8]  = mk(MD_DIV,   0, 0, 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 0, 0);
    vecs[9]  = mk(MD_DIV,   0, 0, 32'hFFFFFFFB, 0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 1);
    vecs[10] = mk(MD_MADD,  0, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    vecs[11] = mk(MD_MSUBU, 0, 10, 2, 3, 0, 4, 0, 0);
    vecs[12] = mk(MD_MUL,   32'hAAAA, 32'h5555, 6, 7, 32'hAAAA, 32'h5555, 42, 0);
    vecs[13] = mk(MD_MUL,   1, 2, 32'hFFFFFFFD, 5, 1, 2, 32'hFFFFFFF1, 0);
    vecs[14] = mk(MD_MULT,  0, 0, 32'h12345678, 32'h10, 1, 32'h23456780, 0, 0);
    vecs[15] = mk(MD_MSUBU, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 32'(md_stall), 32'd0);
    chk("rst.dz", 32'(div_zero), 32'd0);
    chk("rst.res", res_out, 32'd0);
    rst_n = 1'b1;
    rd("rst", 0, 0);

    for (int i = 0; i < 16; i++) run(vecs[i], 1'b1, $sformatf("v%0d", i));

    // held op in DONE must not restart: next start comes from IDLE with a full 33-cycle stall
    @(negedge clk);
    md_valid = 1'b1; md_op = MD_MULTU; rs_in = 2; rt_in = 3; #1;
    n = 0;
    while (md_stall && n < 100) begin @(negedge clk); #1; n++; end
    chk("b2b.first", 32'(n), 32'd33);
    @(negedge clk); #1;
    n = 0;
    while (md_stall && n < 100) begin @(negedge clk); #1; n++; end
    chk("b2b.second", 32'(n), 32'd33);
    @(negedge clk);
    md_valid = 1'b0; md_op = MD_NOP;
    rd("b2b", 0, 6);

    mt(MD_MTHI, 32'hBEEF);
    mt(MD_MTLO, 32'h1234);
    @(negedge clk);
    md_valid = 1'b1; md_op = MD_MULTU; rs_in = 3; rt_in = 5; #1;
    chk("kill.issue_stall", 32'(md_stall), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("kill.busy_stall", 32'(md_stall), 32'd1);
    md_kill = 1'b1;
    @(negedge clk);
    @(negedge clk);
    md_kill = 1'b0; md_valid = 1'b0; md_op = MD_NOP;
    rd("kill.now", 32'hBEEF, 32'h1234);
    repeat (40) @(negedge clk);
    rd("kill.late", 32'hBEEF, 32'h1234);

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    @(negedge clk);
    md_valid = 1'b1; md_op = MD_DIV; rs_in = 100; rt_in = 7;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0; md_valid = 1'b0; md_op = MD_NOP; #1;
    chk("midrst.stall", 32'(md_stall), 32'd0);
    chk("midrst.dz", 32'(div_zero), 32'd0);
    md_valid = 1'b1; md_op = MD_MFHI; #1;
    chk("midrst.hi", res_out, 32'd0);
    md_op = MD_MFLO; #1;
    chk("midrst.lo", res_out, 32'd0);
    md_valid = 1'b0; md_op = MD_NOP;
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(MD_MUL, 0, 0, 6, 7, 0, 0, 42, 0), 1'b0, "rst_mul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
